// File: rtl/choice_sequencer.sv
// Channel scanner: steps Choice between latched bounds, holding each
// value DWELL cycles, with pause, stop, loop and direction control.
module choice_sequencer #(
  parameter int unsigned DWELL = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Pause,
  input  logic       Loop,
  input  logic       Dir,
  input  logic [3:0] Low,
  input  logic [3:0] High,
  output logic [3:0] Choice,
  output logic       Busy,
  output logic       Wrap,
  output logic       Done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

  state_e     state_q, state_d;
  logic [3:0] choice_q, choice_d;
  logic [3:0] low_q, low_d;
  logic [3:0] high_q, high_d;
  logic       dir_q, dir_d;
  logic       loop_q, loop_d;
  logic [7:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       wrap_q, wrap_d;
  logic       done_q, done_d;

  logic       step;
  logic       at_end;
  logic [3:0] start_bound;

  assign at_end      = dir_q ? (choice_q == low_q)
                             : (choice_q == high_q);
  assign start_bound = dir_q ? high_q : low_q;

  always_comb begin
    state_d  = state_q;
    choice_d = choice_q;
    low_d    = low_q;
    high_d   = high_q;
    dir_d    = dir_q;
    loop_d   = loop_q;
    cnt_d    = cnt_q;
    wrap_d   = 1'b0;
    done_d   = 1'b0;
    step     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Start && (Low <= High)) begin
          low_d    = Low;
          high_d   = High;
          dir_d    = Dir;
          loop_d   = Loop;
          choice_d = Dir ? High : Low;
          cnt_d    = 8'd0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (Stop) begin
          state_d = IDLE;
        end else if (Pause) begin
          state_d = PAUSE;
        end else begin
          step = 1'b1;
        end
      end
      PAUSE: begin
        if (Stop) begin
          state_d = IDLE;
        end else if (!Pause) begin
          // the resume edge is itself a counted dwell cycle
          state_d = RUN;
          step    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (step) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = 8'd0;
        if (at_end) begin
          if (loop_q) begin
            choice_d = start_bound;
            wrap_d   = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else if (dir_q) begin
          choice_d = choice_q - 4'd1;
        end else begin
          choice_d = choice_q + 4'd1;
        end
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      choice_q <= 4'd0;
      low_q    <= 4'd0;
      high_q   <= 4'd0;
      dir_q    <= 1'b0;
      loop_q   <= 1'b0;
      cnt_q    <= 8'd0;
      busy_q   <= 1'b0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      choice_q <= choice_d;
      low_q    <= low_d;
      high_q   <= high_d;
      dir_q    <= dir_d;
      loop_q   <= loop_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
    end
  end

  assign Choice = choice_q;
  assign Busy   = busy_q;
  assign Wrap   = wrap_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_choice_sequencer.sv
// Bench for choice_sequencer: vector table, directed corner sequences
// and random traffic against an elapsed-time reference model.
module tb_choice_sequencer;

  logic       Clock = 1'b0;
  logic       Reset, Start, Stop, Pause, Loop, Dir;
  logic [3:0] Low, High;
  logic [3:0] ch4, ch1;
  logic       busy4, wrap4, done4;
  logic       busy1, wrap1, done1;

  int checks = 0;
  int fails  = 0;

  always #5 Clock = ~Clock;

  choice_sequencer #(.DWELL(4)) dut4 (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop),
    .Pause(Pause), .Loop(Loop), .Dir(Dir), .Low(Low), .High(High),
    .Choice(ch4), .Busy(busy4), .Wrap(wrap4), .Done(done4)
  );

  choice_sequencer #(.DWELL(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop),
    .Pause(Pause), .Loop(Loop), .Dir(Dir), .Low(Low), .High(High),
    .Choice(ch1), .Busy(busy1), .Wrap(wrap1), .Done(done1)
  );

  // model: t = active cycles elapsed in the current pass
  typedef struct {
    int mode;
    int t;
    int lo;
    int hi;
    bit dir;
    bit loop;
    int ch;
    bit wrap;
    bit done;
  } mdl_t;

  mdl_t m4, m1;

  function automatic mdl_t mstep(mdl_t m, int dwell, bit st, bit sp,
                                 bit pa, bit lp, bit dr, int lo, int hi);
    m.wrap = 1'b0;
    m.done = 1'b0;
    if (m.mode == 0) begin
      if (st && lo <= hi) begin
        m.lo = lo; m.hi = hi; m.dir = dr; m.loop = lp;
        m.t = 0; m.mode = 1;
        m.ch = dr ? hi : lo;
      end
    end else if (sp) begin
      m.mode = 0;
    end else if (pa) begin
      if (m.mode == 1) m.mode = 2;
    end else begin
      m.mode = 1;
      m.t++;
      if (m.t == (m.hi - m.lo + 1) * dwell) begin
        if (m.loop) begin
          m.t = 0;
          m.wrap = 1'b1;
        end else begin
          m.done = 1'b1;
          m.mode = 0;
        end
      end
      if (m.mode != 0)
        m.ch = m.dir ? m.hi - m.t / dwell : m.lo + m.t / dwell;
    end
    return m;
  endfunction

  function automatic mdl_t mreset();
    mdl_t m;
    m.mode = 0; m.t = 0; m.lo = 0; m.hi = 0;
    m.dir = 0; m.loop = 0; m.ch = 0; m.wrap = 0; m.done = 0;
    return m;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    m4 = mstep(m4, 4, Start, Stop, Pause, Loop, Dir, int'(Low), int'(High));
    m1 = mstep(m1, 1, Start, Stop, Pause, Loop, Dir, int'(Low), int'(High));
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    m4 = mreset();
    m1 = mreset();
  endtask

  task automatic idle_in();
    Start = 0; Stop = 0; Pause = 0;
  endtask

  typedef struct {
    bit         st;
    bit         lp;
    bit         dr;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] ch;
    bit         busy;
    bit         wrap;
    bit         done;
  } vec_t;

  vec_t tbl[20];

  initial begin
    for (int i = 0; i < 18; i++) begin
      tbl[i].st   = (i == 0);
      tbl[i].lp   = (i > 0 && i < 16);
      tbl[i].dr   = (i > 0 && i < 16);
      tbl[i].lo   = (i > 0 && i < 16) ? 4'd0 : 4'd2;
      tbl[i].hi   = (i > 0 && i < 16) ? 4'd15 : 4'd5;
      tbl[i].ch   = (i < 16) ? 4'(2 + i / 4) : 4'd5;
      tbl[i].busy = (i < 16);
      tbl[i].wrap = 1'b0;
      tbl[i].done = (i == 16);
    end
    tbl[18] = '{1'b1, 1'b0, 1'b0, 4'd9, 4'd3, 4'd5, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 4'd9, 4'd3, 4'd5, 1'b0, 1'b0, 1'b0};

    idle_in();
    Loop = 0; Dir = 0; Low = 0; High = 0;
    do_reset();
    chk("reset choice", int'(ch4), 0);
    chk("reset busy", int'(busy4), 0);
    chk("reset wrap_done", int'({wrap4, done4}), 0);

    for (int i = 0; i < 20; i++) begin
      Start = tbl[i].st; Loop = tbl[i].lp; Dir = tbl[i].dr;
      Low = tbl[i].lo; High = tbl[i].hi;
      tick();
      chk($sformatf("tbl%0d choice", i), int'(ch4), int'(tbl[i].ch));
      chk($sformatf("tbl%0d busy", i), int'(busy4), int'(tbl[i].busy));
      chk($sformatf("tbl%0d wrap", i), int'(wrap4), int'(tbl[i].wrap));
      chk($sformatf("tbl%0d done", i), int'(done4), int'(tbl[i].done));
    end
    idle_in();

    // asynchronous reset between edges mid-scan
    Start = 1; Low = 2; High = 5; Dir = 0; Loop = 0;
    tick();
    Start = 0;
    tick(); tick();
    #3 Reset = 1'b1;
    #1;
    chk("async rst choice", int'(ch4), 0);
    chk("async rst busy", int'(busy4), 0);
    @(posedge Clock);
    #1 Reset = 1'b0;
    m4 = mreset(); m1 = mreset();
    Start = 1; Low = 7; High = 8; Dir = 1;
    tick();
    chk("restart choice", int'(ch4), 8);
    chk("restart busy", int'(busy4), 1);
    Start = 0; Stop = 1;
    tick();
    Stop = 0;

    // pause three cycles during the second cycle of Choice=3
    begin
      int n3;
      n3 = 0;
      Start = 1; Low = 2; High = 5; Dir = 0; Loop = 0;
      tick();
      Start = 0;
      for (int k = 1; k <= 12; k++) begin
        Pause = (k >= 6 && k <= 8);
        tick();
        if (ch4 == 4'd3) n3++;
        if (k == 10) chk("pause last3", int'(ch4), 3);
        if (k == 11) chk("pause then4", int'(ch4), 4);
      end
      chk("pause dwell3", n3, 7);
    end
    Pause = 0; Stop = 1;
    tick();
    Stop = 0;

    // stop coincident with looping end-bound advance
    Start = 1; Low = 2; High = 3; Dir = 0; Loop = 1;
    tick();
    Start = 0;
    for (int k = 1; k <= 7; k++) tick();
    Stop = 1;
    tick();
    Stop = 0;
    chk("stop@end busy", int'(busy4), 0);
    chk("stop@end wrap", int'(wrap4), 0);
    chk("stop@end choice", int'(ch4), 3);
    tick();
    chk("stop@end wrap2", int'(wrap4), 0);

    // single-channel loop: Wrap every DWELL cycles
    Start = 1; Low = 6; High = 6; Dir = 0; Loop = 1;
    tick();
    Start = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("single k%0d", k), int'({ch4, wrap4}),
          int'({4'd6, (k % 4 == 0)}));
    end
    Stop = 1;
    tick();
    Stop = 0;

    // DWELL=1 down-scan at top of range
    Start = 1; Low = 14; High = 15; Dir = 1; Loop = 1;
    tick();
    Start = 0;
    chk("d1 first", int'(ch1), 15);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("d1 k%0d", k), int'({ch1, wrap1, busy1}),
          int'({(k % 2 == 1) ? 4'd14 : 4'd15, (k % 2 == 0), 1'b1}));
    end
    Stop = 1;
    tick();
    Stop = 0;
    chk("d1 stop", int'({busy1, wrap1}), 0);

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int lo, hi;
      Start = ($urandom % 4 == 0);
      Stop  = ($urandom % 24 == 0);
      Pause = ($urandom % 6 == 0);
      Loop  = 1'($urandom % 2);
      Dir   = 1'($urandom % 2);
      lo = int'($urandom % 16);
      if ($urandom % 5 == 0) hi = int'($urandom % 16);
      else hi = lo + int'($urandom % 3);
      if (hi > 15) hi = 15;
      Low = 4'(lo); High = 4'(hi);
      tick();
      chk($sformatf("rnd4 n%0d", n), int'({ch4, busy4, wrap4, done4}),
          int'({4'(m4.ch), m4.mode != 0, m4.wrap, m4.done}));
      chk($sformatf("rnd1 n%0d", n), int'({ch1, busy1, wrap1, done1}),
          int'({4'(m1.ch), m1.mode != 0, m1.wrap, m1.done}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
